// File: rtl/vga_sprite_physics.sv
// rtl/vga_sprite_physics.sv - player sprite with frame-synchronous motion, jump/gravity FSM and prioritised pixel colour
// All motion is committed on the registered frame strobe; rgb is purely combinational from the current scan position.
module vga_sprite_physics #(
  parameter int SPRITE_W    = 40,
  parameter int SPRITE_H    = 40,
  parameter int X_MIN       = 144,
  parameter int X_MAX       = 783,
  parameter int X_INIT      = 340,
  parameter int FLOOR_Y     = 320,
  parameter int MOVE_STEP   = 4,
  parameter int JUMP_V      = 15,
  parameter int MAX_FALL    = 16,
  parameter int GRAVITY_DIV = 2,
  parameter int FRAME_LINE  = 515,
  parameter int BOX_X0      = 250,
  parameter int BOX_X1      = 700,
  parameter int BOX_Y0      = 200,
  parameter int BOX_Y1      = 350,
  parameter logic [11:0] C_BLANK  = 12'h0F0,
  parameter logic [11:0] C_SPRITE = 12'h000,
  parameter logic [11:0] C_BOX    = 12'hEA7,
  parameter logic [11:0] C_BG     = 12'hE83
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [15:0] score,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic        airborne
);

  typedef enum logic [1:0] {S_GROUND, S_RISE, S_FALL} state_t;

  localparam logic signed [10:0] L_X_LO  = 11'(X_MIN);
  localparam logic signed [10:0] L_X_HI  = 11'(X_MAX - SPRITE_W + 1);
  localparam logic signed [10:0] L_STEP  = 11'(MOVE_STEP);
  localparam logic signed [10:0] L_FLOOR = 11'(FLOOR_Y);
  localparam logic signed [5:0]  L_JUMP  = 6'(JUMP_V);
  localparam logic signed [5:0]  L_NEG_MAX = 6'(-MAX_FALL);
  localparam logic [7:0]         L_GDIV_M1 = 8'(GRAVITY_DIV - 1);

  state_t             r_state, w_state_next;
  logic [9:0]         r_x, r_y, w_x_n, w_y_n, w_x_clamped;
  logic signed [5:0]  r_vel, w_vel_n, w_vel_grav, w_vel_air;
  logic [7:0]         r_grav_cnt, w_cnt_n, w_cnt_grav;
  logic [15:0]        r_score;
  logic               r_jump_pend, r_frame_cond_d, r_tick, w_frame_cond, w_score_inc;
  logic signed [10:0] w_x_ext, w_x_step, w_y_next;
  logic               w_sprite_hit, w_box_hit;

  assign w_frame_cond = (hCount == 10'd0) && (vCount == 10'(FRAME_LINE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cond_d <= 1'b0;
      r_tick         <= 1'b0;
    end else begin
      r_frame_cond_d <= w_frame_cond;
      r_tick         <= w_frame_cond & ~r_frame_cond_d;
    end
  end

  // Horizontal step and gravity candidates, evaluated every clk but only committed on r_tick.
  always_comb begin
    w_x_ext  = {1'b0, r_x};
    w_x_step = w_x_ext;
    if (right && !left)      w_x_step = w_x_ext + L_STEP;
    else if (left && !right) w_x_step = w_x_ext - L_STEP;
    if (w_x_step < L_X_LO)      w_x_clamped = L_X_LO[9:0];
    else if (w_x_step > L_X_HI) w_x_clamped = L_X_HI[9:0];
    else                        w_x_clamped = w_x_step[9:0];
    w_y_next   = $signed({1'b0, r_y}) - $signed({{5{r_vel[5]}}, r_vel});
    w_cnt_grav = (r_grav_cnt == L_GDIV_M1) ? 8'd0 : r_grav_cnt + 8'd1;
    w_vel_grav = r_vel;
    if (r_grav_cnt == L_GDIV_M1)
      w_vel_grav = (r_vel > L_NEG_MAX) ? r_vel - 6'sd1 : L_NEG_MAX;
    w_vel_air = down ? L_NEG_MAX : w_vel_grav;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_GROUND;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_x_n        = r_tick ? w_x_clamped : r_x;
    w_y_n        = r_y;
    w_vel_n      = r_vel;
    w_cnt_n      = r_grav_cnt;
    w_score_inc  = 1'b0;
    if (r_tick) begin
      case (r_state)
        S_GROUND: begin
          if (r_jump_pend) begin
            w_vel_n      = L_JUMP;
            w_cnt_n      = 8'd0;
            w_state_next = S_RISE;
          end
        end
        S_RISE, S_FALL: begin
          if (r_state == S_FALL && w_y_next >= L_FLOOR) begin
            w_y_n        = L_FLOOR[9:0];
            w_vel_n      = 6'sd0;
            w_score_inc  = 1'b1;
            w_state_next = S_GROUND;
          end else begin
            w_y_n   = w_y_next[9:0];
            w_vel_n = w_vel_air;
            w_cnt_n = w_cnt_grav;
            if (w_y_next < 11'sd0) begin
              w_y_n        = 10'd0;
              w_vel_n      = 6'sd0;
              w_state_next = S_FALL;
            end else if (r_state == S_RISE && w_vel_air <= 6'sd0) begin
              w_state_next = S_FALL;
            end
          end
        end
        default: w_state_next = S_GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= 10'(X_INIT);
      r_y         <= 10'(FLOOR_Y);
      r_vel       <= 6'sd0;
      r_grav_cnt  <= 8'd0;
      r_score     <= 16'd0;
      r_jump_pend <= 1'b0;
    end else begin
      r_x        <= w_x_n;
      r_y        <= w_y_n;
      r_vel      <= w_vel_n;
      r_grav_cnt <= w_cnt_n;
      if (w_score_inc && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
      if (r_state != S_GROUND) r_jump_pend <= 1'b0;
      else if (up)             r_jump_pend <= 1'b1;
      else if (r_tick)         r_jump_pend <= 1'b0;
    end
  end

  always_comb begin
    w_sprite_hit = ({1'b0, hCount} >= {1'b0, r_x}) && ({1'b0, hCount} <= {1'b0, r_x} + 11'(SPRITE_W - 1)) &&
                   ({1'b0, vCount} >= {1'b0, r_y}) && ({1'b0, vCount} <= {1'b0, r_y} + 11'(SPRITE_H - 1));
    w_box_hit    = (hCount >= 10'(BOX_X0)) && (hCount <= 10'(BOX_X1)) &&
                   (vCount >= 10'(BOX_Y0)) && (vCount <= 10'(BOX_Y1));
    airborne = (r_state != S_GROUND);
    if (!bright)           rgb = C_BLANK;
    else if (w_sprite_hit) rgb = C_SPRITE;
    else if (w_box_hit)    rgb = C_BOX;
    else                   rgb = C_BG;
  end

  assign sprite_x = r_x;
  assign sprite_y = r_y;
  assign score    = r_score;

endmodule

// File: tb/tb_vga_sprite_physics.sv
// tb/tb_vga_sprite_physics.sv - scoreboard bench for vga_sprite_physics
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_vga_sprite_physics;

  logic        clk = 1'b0;
  logic        reset, bright, up, down, left, right;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb;
  logic [15:0] score;
  logic [9:0]  sprite_x, sprite_y;
  logic        airborne;

  vga_sprite_physics dut (
    .clk(clk), .reset(reset), .bright(bright), .up(up), .down(down),
    .left(left), .right(right), .hCount(hCount), .vCount(vCount),
    .rgb(rgb), .score(score), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .airborne(airborne)
  );

  always #5 clk = ~clk;

  localparam int K_X = 0, K_Y = 1, K_SCORE = 2, K_AIR = 3, K_RGB = 4;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int actual_of(int kind);
    case (kind)
      K_X:     return int'(sprite_x);
      K_Y:     return int'(sprite_y);
      K_SCORE: return int'(score);
      K_AIR:   return int'(airborne);
      default: return int'(rgb);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = actual_of(e.kind);
      total++;
      if (act != e.exp) begin
        bad++;
        $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", e.name, act, act, e.exp, e.exp, $time);
      end
    end
  end

  task automatic push(input string n, input int k, input int v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic settle();
    int n;
    @(negedge clk); #1;
    n = 0;
    while (q.size() > 0 && n < 4) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL monitor_drain pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  task automatic frame_n(input int hold);
    @(posedge clk); #1;
    hCount = 10'd0;
    vCount = 10'd515;
    repeat (hold) @(posedge clk);
    #1;
    hCount = 10'd1;
    vCount = 10'd0;
    @(posedge clk); #1;
  endtask

  task automatic frames(input int n);
    repeat (n) frame_n(1);
  endtask

  task automatic pulse_up();
    @(posedge clk); #1 up = 1'b1;
    @(posedge clk); #1 up = 1'b0;
  endtask

  task automatic pixel(input string n, input int h, input int v, input logic b, input int exp);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
    push(n, K_RGB, exp);
    settle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bright = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    hCount = 10'd1; vCount = 10'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push("rst_x", K_X, 340); push("rst_y", K_Y, 320);
    push("rst_score", K_SCORE, 0); push("rst_air", K_AIR, 0);
    settle();

    frames(3);
    push("idle_x", K_X, 340); push("idle_y", K_Y, 320);
    push("idle_score", K_SCORE, 0); push("idle_air", K_AIR, 0);
    settle();

    pixel("pix_sprite", 360, 330, 1'b1, 12'h000);
    pixel("pix_box", 260, 210, 1'b1, 12'hEA7);
    pixel("pix_bg", 100, 100, 1'b1, 12'hE83);
    pixel("pix_sprite_corner", 379, 359, 1'b1, 12'h000);
    pixel("pix_past_corner", 380, 359, 1'b1, 12'hE83);
    pixel("pix_blank", 360, 330, 1'b0, 12'h0F0);
    hCount = 10'd1; vCount = 10'd0; bright = 1'b0;

    left = 1'b1; right = 1'b1;
    frames(4);
    push("lr_both_x", K_X, 340);
    settle();
    left = 1'b0; right = 1'b0;

    pulse_up();
    frames(1);
    push("launch_air", K_AIR, 1); push("launch_y", K_Y, 320); settle();
    frames(1); push("rise1_y", K_Y, 305); settle();
    frames(1); push("rise2_y", K_Y, 290); settle();
    frames(1); push("rise3_y", K_Y, 276); settle();
    frames(27); push("apex_y", K_Y, 80); push("apex_air", K_AIR, 1); settle();
    frames(30); push("fall60_y", K_Y, 290); push("fall60_air", K_AIR, 1); settle();
    frames(1); push("fall61_y", K_Y, 305); settle();
    frames(1);
    push("land_y", K_Y, 320); push("land_air", K_AIR, 0); push("land_score", K_SCORE, 1);
    settle();

    pulse_up();
    frames(1); push("dn_launch_y", K_Y, 320); settle();
    frames(1); push("dn_t1_y", K_Y, 305); settle();
    down = 1'b1;
    frames(1); push("dn_t2_y", K_Y, 290); push("dn_t2_air", K_AIR, 1); settle();
    frames(1); push("dn_t3_y", K_Y, 306); settle();
    frames(1);
    push("dn_land_y", K_Y, 320); push("dn_land_air", K_AIR, 0); push("dn_land_score", K_SCORE, 2);
    settle();
    down = 1'b0;
    frames(1); push("dn_rest_y", K_Y, 320); push("dn_rest_score", K_SCORE, 2); settle();

    up = 1'b1; down = 1'b1;
    frames(1); push("hold_launch_air", K_AIR, 1); settle();
    frames(1); push("hold_t1_y", K_Y, 305); settle();
    frames(1); push("hold_land_air", K_AIR, 0); push("hold_land_score", K_SCORE, 3); settle();
    frames(1); push("hold_relaunch_air", K_AIR, 1); push("hold_relaunch_y", K_Y, 320); settle();
    up = 1'b0;
    frames(2); push("hold_land2_score", K_SCORE, 4); push("hold_land2_y", K_Y, 320); settle();
    down = 1'b0;

    right = 1'b1;
    frames(100); push("right_740", K_X, 740); settle();
    frames(1);   push("right_clamp", K_X, 744); settle();
    frames(1);   push("right_hold", K_X, 744); settle();
    right = 1'b0; left = 1'b1;
    frames(149); push("left_148", K_X, 148); settle();
    frames(1);   push("left_clamp", K_X, 144); settle();
    frames(1);   push("left_hold", K_X, 144); settle();
    left = 1'b0;

    right = 1'b1;
    frame_n(6);
    push("edge_one_tick_x", K_X, 148);
    settle();
    right = 1'b0;

    pulse_up();
    frames(6);
    push("pre_rst_y", K_Y, 249); push("pre_rst_air", K_AIR, 1);
    settle();
    @(posedge clk); #1 reset = 1'b1;
    push("async_rst_y", K_Y, 320); push("async_rst_air", K_AIR, 0);
    push("async_rst_score", K_SCORE, 0); push("async_rst_x", K_X, 340);
    settle();
    reset = 1'b0;
    frames(1);
    push("post_rst_y", K_Y, 320); push("post_rst_air", K_AIR, 0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
